updn_mod_counter: RTL and testbench

//  Next-generation parametrised counter: up/down, runtime modulo limit, wrap or saturate mode.

---
 rtl/cnt_pkg.sv | 10 +
 rtl/updn_mod_counter.sv | 108 ++++++++++
 tb/tb_updn_mod_counter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared constants for the up/down modulo counter.
// Direction and mode encodings used by RTL and bench.
package cnt_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updn_mod_counter.sv
// Up/down counter with runtime limit, wrap or saturate mode.
// All outputs are registered from the same next-count value.
module updn_mod_counter
  import cnt_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             wrap,
  output logic             at_bound,
  output logic             match
);

  localparam logic AB_RST = (RST_VAL == '0);

  function automatic logic [WIDTH-1:0] next_cnt(
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] l,
    input logic             d,
    input logic             s
  );
    logic [WIDTH:0] ce;
    logic [WIDTH:0] le;
    ce = {1'b0, c};
    le = {1'b0, l};
    if (ce > le) begin
      return l;
    end
    if (d == DIR_UP) begin
      if (ce == le) begin
        return (s == MODE_SAT) ? l : '0;
      end
      return WIDTH'(ce + 1'b1);
    end
    if (ce == '0) begin
      return (s == MODE_SAT) ? '0 : l;
    end
    return WIDTH'(ce - 1'b1);
  endfunction

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] cnt_d;
  logic             over;
  logic             edge_hit;
  logic             step_wrap;
  logic             step_hold;
  logic             tc_d;
  logic             wrap_d;
  logic             ab_d;
  logic             match_d;

  assign nxt       = next_cnt(cnt_out, limit, dir, sat);
  assign term      = (dir == DIR_UP) ? limit : '0;
  assign over      = cnt_out > limit;
  assign edge_hit  = ~over & (cnt_out == term);
  assign step_wrap = edge_hit & (sat == MODE_WRAP);
  assign step_hold = edge_hit & (sat == MODE_SAT);

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    cnt_d  = cnt_out;
    tc_d   = 1'b0;
    wrap_d = 1'b0;
    priority case (1'b1)
      clr: cnt_d = '0;
      load: cnt_d = (load_val > limit) ? limit : load_val;
      en: begin
        cnt_d  = nxt;
        wrap_d = step_wrap;
        tc_d   = ~step_wrap & ~step_hold & (nxt == term);
      end
      default: ;
    endcase
    ab_d    = (dir == DIR_UP) ? (cnt_d == limit) : (cnt_d == '0);
    match_d = (cnt_d == cmp_val);
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_out  <= RST_VAL;
      tc       <= 1'b0;
      wrap     <= 1'b0;
      at_bound <= AB_RST;
      match    <= 1'b0;
    end else begin
      cnt_out  <= cnt_d;
      tc       <= tc_d;
      wrap     <= wrap_d;
      at_bound <= ab_d;
      match    <= match_d;
    end
  end

endmodule

// File: tb/tb_updn_mod_counter.sv
// Randomized and directed bench for updn_mod_counter.
// Behavioural integer model checks every cycle.
module tb_updn_mod_counter;

  localparam int W  = 5;
  localparam int RV = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic         sat = 1'b0;
  logic [W-1:0] limit = 5'd20;
  logic [W-1:0] cmp_val = 5'd31;
  logic [W-1:0] cnt_out;
  logic         tc;
  logic         wrap;
  logic         at_bound;
  logic         match;

  int errs = 0;
  int checks = 0;
  int m_cnt;
  bit m_tc;
  bit m_wrap;
  bit m_ab;
  bit m_match;

  updn_mod_counter #(.WIDTH(W), .RST_VAL(5'(RV))) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .load_val(load_val), .en(en), .dir(dir), .sat(sat),
    .limit(limit), .cmp_val(cmp_val), .cnt_out(cnt_out),
    .tc(tc), .wrap(wrap), .at_bound(at_bound), .match(match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model();
    int lim;
    int trm;
    lim = int'(limit);
    m_tc = 0;
    m_wrap = 0;
    if (clr) begin
      m_cnt = 0;
    end else if (load) begin
      m_cnt = (int'(load_val) < lim) ? int'(load_val) : lim;
    end else if (en) begin
      trm = dir ? lim : 0;
      if (m_cnt > lim) begin
        m_cnt = lim;
        m_tc = (m_cnt == trm);
      end else if (m_cnt == trm) begin
        if (!sat) begin
          m_wrap = 1;
          m_cnt = dir ? 0 : lim;
        end
      end else begin
        m_cnt = dir ? m_cnt + 1 : m_cnt - 1;
        m_tc = (m_cnt == trm);
      end
    end
    m_ab = dir ? (m_cnt == lim) : (m_cnt == 0);
    m_match = (m_cnt == int'(cmp_val));
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("cnt", int'(cnt_out), m_cnt);
    chk("tc", int'(tc), int'(m_tc));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("at_bound", int'(at_bound), int'(m_ab));
    chk("match", int'(match), int'(m_match));
  endtask

  initial begin
    m_cnt = RV;
    #12;
    rst_n = 1'b1;
    // 1: count to 7 then async reset mid-cycle
    load = 1'b1; load_val = 5'd6; cyc();
    load = 1'b0; en = 1'b1; cyc();
    chk("t1_pre", int'(cnt_out), 7);
    #2 rst_n = 1'b0;
    #1;
    m_cnt = RV;
    chk("t1_rst_cnt", int'(cnt_out), RV);
    chk("t1_rst_tc", int'(tc), 0);
    chk("t1_rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    repeat (2) cyc();
    chk("t1_hold", int'(cnt_out), RV);

    // 2: limit 9 up wrap from 0
    limit = 5'd9; dir = 1'b1; sat = 1'b0;
    clr = 1'b1; cyc(); clr = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("t2_cnt", int'(cnt_out), i % 10);
      chk("t2_tc", int'(tc), int'(i == 9));
      chk("t2_wrap", int'(wrap), int'(i == 10));
    end

    // 3: limit 9 down sat from 2
    en = 1'b0; load = 1'b1; load_val = 5'd2; cyc(); load = 1'b0;
    dir = 1'b0; sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_cnt", int'(cnt_out), (i == 0) ? 1 : 0);
      chk("t3_tc", int'(tc), int'(i == 1));
      chk("t3_wrap", int'(wrap), 0);
      chk("t3_ab", int'(at_bound), int'(i >= 1));
    end

    // 4: clr beats load beats en; load clamps
    clr = 1'b1; load = 1'b1; load_val = 5'd5; cyc();
    chk("t4_clr", int'(cnt_out), 0);
    clr = 1'b0; load_val = 5'd20; cyc();
    chk("t4_clamp", int'(cnt_out), 9);
    load = 1'b0;

    // 5: limit lowered below count
    limit = 5'd20; load = 1'b1; load_val = 5'd15; cyc();
    load = 1'b0; limit = 5'd6; dir = 1'b1; sat = 1'b0; cyc();
    chk("t5_clamp", int'(cnt_out), 6);
    chk("t5_nowrap", int'(wrap), 0);
    cyc();
    chk("t5_wrap_cnt", int'(cnt_out), 0);
    chk("t5_wrap", int'(wrap), 1);

    // 6: compare match, then limit 0 wrap
    limit = 5'd9; cmp_val = 5'd3; clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("t6_match", int'(match), int'(i == 3));
    end
    limit = 5'd0; clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_l0_cnt", int'(cnt_out), 0);
      chk("t6_l0_wrap", int'(wrap), 1);
    end
    en = 1'b0; cyc();
    chk("t6_l0_idle", int'(wrap), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      clr      = ($urandom_range(0, 99) < 4);
      load     = ($urandom_range(0, 99) < 8);
      load_val = W'($urandom);
      en       = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) sat = ~sat;
      if ($urandom_range(0, 19) == 0) limit = W'($urandom);
      if ($urandom_range(0, 9) == 0) cmp_val = W'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
